// File: rtl/mdr_mem_if.sv
// Memory data register with a variable-latency memory handshake.
// The register loads straight from the internal bus, or runs one read/write transaction.
// Reads extract byte/halfword/word lanes, with optional sign extension.
// Writes replicate the low bytes of data_out across every lane and drive byte enables.
module mdr_mem_if #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned OFF_W       = 2,
   parameter int unsigned TIMEOUT     = 16,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [DATA_W-1:0]   bus_data_in,
   input  logic                load_bus,
   input  logic                rd_start,
   input  logic                wr_start,
   input  logic [1:0]          size,
   input  logic                sign_ext,
   input  logic [OFF_W-1:0]    byte_off,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   data_out,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int unsigned BE_W  = DATA_W / 8;
   // The counter only has to reach TIMEOUT-1; the abort happens on the edge after that.
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        size_q;
   logic              sign_q;
   logic [OFF_W-1:0]  off_q;

   // Access width in bytes for a size code.
   function automatic int unsigned size_bytes(input logic [1:0] sz);
      unique case (sz)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return BE_W;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
      unique case (sz)
         2'b00:   return 1'b0;
         2'b01:   return off[0];
         2'b10:   return off[1:0] != 2'b00;
         default: return off != '0;
      endcase
   endfunction

   function automatic logic [BE_W-1:0] lane_mask(input logic [1:0] sz,
                                                 input logic [OFF_W-1:0] off);
      logic [BE_W-1:0] m;
      unique case (sz)
         2'b00:   m = BE_W'(4'h1);
         2'b01:   m = BE_W'(4'h3);
         2'b10:   m = BE_W'(4'hF);
         default: m = '1;
      endcase
      return m << off;
   endfunction

   // Lane k of the write data carries byte (k mod access-width) of the register.
   function automatic logic [DATA_W-1:0] replicate(input logic [1:0] sz,
                                                   input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] w;
      int unsigned n;
      w = '0;
      n = size_bytes(sz);
      for (int unsigned i = 0; i < BE_W; i++) begin
         w[8*i +: 8] = d[8*(i % n) +: 8];
      end
      return w;
   endfunction

   // Shift the addressed lanes down, keep the access width, and fill the rest.
   function automatic logic [DATA_W-1:0] extract(input logic [1:0] sz, input logic sx,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [DATA_W-1:0] rdata);
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] keep;
      logic              sbit;
      sh = rdata >> {off, 3'b000};
      unique case (sz)
         2'b00:   begin keep = DATA_W'(8'hFF);         sbit = sh[7];  end
         2'b01:   begin keep = DATA_W'(16'hFFFF);      sbit = sh[15]; end
         2'b10:   begin keep = DATA_W'(32'hFFFF_FFFF); sbit = sh[31]; end
         default: begin keep = '1;                     sbit = 1'b0;   end
      endcase
      return (sh & keep) | ((sx && sbit) ? ~keep : '0);
   endfunction

   // Transaction FSM; every output is a register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         size_q    <= 2'b00;
         sign_q    <= 1'b0;
         off_q     <= '0;
         data_out  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         mem_be    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (rd_start || wr_start) begin
                  size_q <= size;
                  sign_q <= sign_ext;
                  off_q  <= byte_off;
                  cnt_q  <= '0;
                  if (ALIGN_CHECK && misaligned(size, byte_off)) begin
                     err <= 1'b1;
                  end else begin
                     mem_req <= 1'b1;
                     mem_we  <= !rd_start;
                     mem_be  <= lane_mask(size, byte_off);
                     busy    <= 1'b1;
                     if (rd_start) begin
                        state_q <= StRdWait;
                     end else begin
                        mem_wdata <= replicate(size, data_out);
                        state_q   <= StWrWait;
                     end
                  end
               end else if (load_bus) begin
                  data_out <= bus_data_in;
               end
            end
            StRdWait, StWrWait: begin
               if (mem_ack) begin
                  if (state_q == StRdWait) begin
                     data_out <= extract(size_q, sign_q, off_q, mem_rdata);
                  end
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  mem_be  <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StIdle;
               end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  mem_be  <= '0;
                  busy    <= 1'b0;
                  err     <= 1'b1;
                  state_q <= StIdle;
               end else if (TIMEOUT != 0) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/mdr_mem_if.md
Name: mdr_mem_if

Overview:
- Parametrised memory data register with a built-in memory-side handshake.
- Holds the datapath operand like a plain MDR: loads directly from the CPU bus, or runs a read/write transaction with variable-latency memory.
- Reads: byte/halfword/word lane extraction with optional sign extension. Writes: lane replication and byte enables.
- Sits between the internal bus and the memory subsystem, replacing the fixed single-cycle MDR.

Parameters:
DATA_W, 32, register/bus width in bits; multiple of 8, >= 32
OFF_W, 2, byte-offset width = log2(DATA_W/8)
TIMEOUT, 16, max wait cycles for mem_ack before error; 0 disables timeout
ALIGN_CHECK, 1, 1 = misaligned halfword/word access raises err without issuing a request

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset, asynchronous, active-high
bus_data_in  in  DATA_W  internal bus data
load_bus  in  1  load data_out from bus_data_in (IDLE only)
rd_start  in  1  start memory read (1-cycle pulse)
wr_start  in  1  start memory write of data_out (1-cycle pulse)
size  in  2  00 byte, 01 halfword, 10 word (32b), 11 full DATA_W
sign_ext  in  1  sign-extend byte/halfword reads
byte_off  in  OFF_W  byte offset within DATA_W word
mem_rdata  in  DATA_W  memory read data
mem_ack  in  1  memory completion, valid while mem_req high
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_wdata  out  DATA_W  write data
mem_be  out  DATA_W/8  byte enables
data_out  out  DATA_W  register contents to datapath
busy  out  1  transaction in progress
done  out  1  1-cycle pulse after successful completion
err  out  1  1-cycle pulse: timeout or misalignment

Behaviour:
- Reset (async, clr=1): data_out=0, state=IDLE, mem_req=0, mem_we=0, mem_wdata=0, mem_be=0, busy=0, done=0, err=0, timeout counter=0. Takes effect immediately mid-transaction; mem_req drops without waiting for ack.
- States: IDLE, RD_WAIT, WR_WAIT.

IDLE:
- Priority is rd_start > wr_start > load_bus. Lower-priority inputs asserted in the same cycle are ignored.
- load_bus: data_out <= bus_data_in next edge.
- On a start, latch size, sign_ext and byte_off. If ALIGN_CHECK and misaligned (half: byte_off[0]!=0; word: byte_off[1:0]!=0; full: byte_off!=0): err pulse next cycle, stay IDLE, no request.
- rd_start: next edge mem_req=1, mem_we=0, mem_be=lanes of access, go RD_WAIT.
- wr_start: next edge mem_req=1, mem_we=1. mem_wdata = low size-bytes of data_out replicated across all lanes; mem_be = lanes at byte_off. Go WR_WAIT.

RD_WAIT / WR_WAIT:
- busy=1. rd_start, wr_start and load_bus are ignored.
- mem_ack sampled high at an edge: mem_req/mem_we/mem_be clear, return IDLE, done=1 next cycle.
- For reads, data_out <= extracted lanes (mem_rdata >> 8*byte_off), zero- or sign-extended to DATA_W per sign_ext. size 11 and size 10 with DATA_W=32 take the full value.
- Writes never modify data_out.
- Timeout counter increments each wait cycle without ack. When TIMEOUT!=0 and the count reaches TIMEOUT with no ack: drop request, return IDLE, err pulse, data_out unchanged.
- mem_ack outside a wait state is ignored.

Timing and pulses:
- Minimum read latency: rd_start at edge 0, mem_req high cycle 1, ack at edge 1, data_out valid and done high in cycle 2.
- A new start is accepted in the same cycle done is high.
- done and err are never high together.

Test Plan:
- Reset/bus load: clr pulse then load_bus with bus_data_in=0xDEADBEEF -> data_out=0 during clr, 0xDEADBEEF one edge after load; busy, mem_req remain 0.
- Signed byte read, 3-cycle ack: rd_start, size=00, sign_ext=1, byte_off=2, mem_rdata=0x1280_3456, ack on 3rd wait cycle -> mem_be=0100, data_out=0xFFFFFF80, done one pulse, busy high exactly 3 cycles.
- Halfword write: data_out=0x0000ABCD, wr_start, size=01, byte_off=2 -> mem_we=1, mem_wdata=0xABCDABCD, mem_be=1100; after ack data_out still 0x0000ABCD.
- Timeout: TIMEOUT=4, rd_start, never ack -> mem_req high 4 cycles then low, err pulse, data_out unchanged, done never asserted.
- Misaligned/priority: word read byte_off=1 -> err pulse, mem_req never asserts. rd_start+wr_start+load_bus together -> read performed, data_out reflects memory, not bus.
- Reset mid-read: clr asserted in RD_WAIT -> mem_req, busy low immediately, data_out=0; later ack ignored.
